// File: rtl/enemy_bullet_gen_pkg.sv
// Shared game definitions: playfield geometry, frame rate and the bullet FSM encoding.
// Used by both the bullet generator and the collision checker.
package enemy_bullet_gen_pkg;

  localparam int unsigned X_W      = 3;
  localparam int unsigned Y_W      = 5;
  localparam int unsigned Y_MAX    = 31;
  localparam int unsigned TICK_CNT = 800_000;

  typedef logic [2:0] state_t;

  localparam state_t S_WAIT  = 3'd0;
  localparam state_t S_CLEAR = 3'd1;
  localparam state_t S_MOVE  = 3'd2;
  localparam state_t S_SPAWN = 3'd3;
  localparam state_t S_DONE  = 3'd4;

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: one-cycle tick every TICK_CNT+1 enabled clocks.
// Holds its count while disabled so both ends of the collision link keep the same frame phase.
module frame_tick_gen #(
  parameter int unsigned TICK_CNT = enemy_bullet_gen_pkg::TICK_CNT
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Enable,
  output logic o_Tick
);

  localparam int unsigned CW = $clog2(TICK_CNT + 1);

  logic [CW-1:0] cnt_q;

  assign o_Tick = i_Enable && (cnt_q == CW'(TICK_CNT));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      cnt_q <= '0;
    end else if (o_Tick) begin
      cnt_q <= '0;
    end else if (i_Enable) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/enemy_bullet_gen.sv
// Enemy bullet generator: spawns, moves and retires bullets in a fixed slot pool once per frame,
// publishing registered positions to the collision checker.
module enemy_bullet_gen #(
  parameter int unsigned TICK_CNT  = enemy_bullet_gen_pkg::TICK_CNT,
  parameter int unsigned N_BULLET  = 4,
  parameter int unsigned X_W       = enemy_bullet_gen_pkg::X_W,
  parameter int unsigned Y_W       = enemy_bullet_gen_pkg::Y_W,
  parameter int unsigned Y_MAX     = enemy_bullet_gen_pkg::Y_MAX,
  parameter int unsigned MOVE_DIV  = 2,
  parameter int unsigned SPAWN_DIV = 8,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Enable,
  input  logic [N_BULLET-1:0]     i_Hit_Mask,
  output logic [N_BULLET*X_W-1:0] o_Bullet_x,
  output logic [N_BULLET*Y_W-1:0] o_Bullet_y,
  output logic [N_BULLET-1:0]     o_Bullet_vld,
  output logic                    o_Frame,
  output logic [7:0]              o_Dodged
);

  import enemy_bullet_gen_pkg::*;

  localparam int unsigned MCW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int unsigned SCW = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;

  logic tick;

  state_t                         state_q, state_d;
  logic [N_BULLET-1:0]            vld_q, vld_d;
  logic [N_BULLET-1:0][X_W-1:0]   x_q, x_d;
  logic [N_BULLET-1:0][Y_W-1:0]   y_q, y_d;
  logic [7:0]                     dodged_q, dodged_d;
  logic [7:0]                     lfsr_q, lfsr_d, lfsr_next;
  logic [MCW-1:0]                 move_cnt_q, move_cnt_d;
  logic [SCW-1:0]                 spawn_cnt_q, spawn_cnt_d;
  logic                           frame_q, frame_d;
  logic [8:0]                     exit_cnt;
  logic [8:0]                     dodged_sum;
  logic                           spawned;

  frame_tick_gen #(
    .TICK_CNT (TICK_CNT)
  ) u_tick (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Enable (i_Enable),
    .o_Tick   (tick)
  );

  always_comb begin
    state_d     = state_q;
    vld_d       = vld_q;
    x_d         = x_q;
    y_d         = y_q;
    dodged_d    = dodged_q;
    lfsr_d      = lfsr_q;
    move_cnt_d  = move_cnt_q;
    spawn_cnt_d = spawn_cnt_q;
    exit_cnt    = '0;
    dodged_sum  = '0;
    spawned     = 1'b0;
    // Fibonacci taps 8,6,5,4
    lfsr_next   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    frame_d     = (state_q == S_SPAWN);

    case (state_q)
      S_WAIT: begin
        if (tick) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        vld_d   = vld_q & ~i_Hit_Mask;
        state_d = S_MOVE;
      end
      S_MOVE: begin
        if (move_cnt_q == MCW'(MOVE_DIV - 1)) begin
          move_cnt_d = '0;
          for (int unsigned k = 0; k < N_BULLET; k++) begin
            if (vld_q[k]) begin
              if (y_q[k] == Y_W'(Y_MAX)) begin
                vld_d[k] = 1'b0;
                exit_cnt = exit_cnt + 9'd1;
              end else begin
                y_d[k] = y_q[k] + Y_W'(1);
              end
            end
          end
          dodged_sum = {1'b0, dodged_q} + exit_cnt;
          dodged_d   = dodged_sum[8] ? 8'hFF : dodged_sum[7:0];
        end else begin
          move_cnt_d = move_cnt_q + MCW'(1);
        end
        state_d = S_SPAWN;
      end
      S_SPAWN: begin
        if (spawn_cnt_q == SCW'(SPAWN_DIV - 1)) begin
          spawn_cnt_d = '0;
          lfsr_d      = lfsr_next;
          for (int unsigned k = 0; k < N_BULLET; k++) begin
            if (!spawned && !vld_q[k]) begin
              vld_d[k] = 1'b1;
              y_d[k]   = '0;
              x_d[k]   = lfsr_next[X_W-1:0];
              spawned  = 1'b1;
            end
          end
        end else begin
          spawn_cnt_d = spawn_cnt_q + SCW'(1);
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst) begin
      state_q     <= S_WAIT;
      vld_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      dodged_q    <= '0;
      lfsr_q      <= LFSR_SEED;
      move_cnt_q  <= '0;
      spawn_cnt_q <= '0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dodged_q    <= dodged_d;
      lfsr_q      <= lfsr_d;
      move_cnt_q  <= move_cnt_d;
      spawn_cnt_q <= spawn_cnt_d;
      frame_q     <= frame_d;
    end
  end

  assign o_Bullet_x   = x_q;
  assign o_Bullet_y   = y_q;
  assign o_Bullet_vld = vld_q;
  assign o_Frame      = frame_q;
  assign o_Dodged     = dodged_q;

endmodule

// File: tb/tb_enemy_bullet_gen.sv
// Bench for enemy_bullet_gen: two configurations driven in lockstep and compared each cycle
// against a frame-level reference model (whole frame applied at once, outputs checked when idle).
module tb_enemy_bullet_gen;

  localparam int unsigned TICK = 4;
  localparam int unsigned MD [2] = '{1, 1};
  localparam int unsigned SD [2] = '{1, 40};

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  hit [2];
  logic [11:0] bx  [2];
  logic [19:0] by  [2];
  logic [3:0]  bv  [2];
  logic        fr  [2];
  logic [7:0]  dd  [2];

  enemy_bullet_gen #(
    .TICK_CNT (TICK), .N_BULLET (4), .X_W (3), .Y_W (5), .Y_MAX (31),
    .MOVE_DIV (MD[0]), .SPAWN_DIV (SD[0]), .LFSR_SEED (8'hA5)
  ) dut0 (
    .i_Clk (clk), .i_Rst (rst), .i_Enable (en), .i_Hit_Mask (hit[0]),
    .o_Bullet_x (bx[0]), .o_Bullet_y (by[0]), .o_Bullet_vld (bv[0]),
    .o_Frame (fr[0]), .o_Dodged (dd[0])
  );

  enemy_bullet_gen #(
    .TICK_CNT (TICK), .N_BULLET (4), .X_W (3), .Y_W (5), .Y_MAX (31),
    .MOVE_DIV (MD[1]), .SPAWN_DIV (SD[1]), .LFSR_SEED (8'hA5)
  ) dut1 (
    .i_Clk (clk), .i_Rst (rst), .i_Enable (en), .i_Hit_Mask (hit[1]),
    .o_Bullet_x (bx[1]), .o_Bullet_y (by[1]), .o_Bullet_vld (bv[1]),
    .o_Frame (fr[1]), .o_Dodged (dd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: m_age is cycles since the tick cycle (0 = idle), m_nf is frames applied.
  logic [3:0] m_vld  [2];
  logic [2:0] m_x    [2][4];
  logic [4:0] m_y    [2][4];
  int         m_dod  [2];
  logic [7:0] m_lfsr [2];
  int         m_nf   [2];
  int         m_age  [2];
  int         en_cycles;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  chk_on   = 1'b0;
  int  ph       = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic frame_update(input int i, input logic [3:0] h);
    bit found;
    for (int k = 0; k < 4; k++) if (m_vld[i][k] && h[k]) m_vld[i][k] = 1'b0;
    if (m_nf[i] % MD[i] == MD[i] - 1) begin
      for (int k = 0; k < 4; k++) begin
        if (m_vld[i][k]) begin
          if (m_y[i][k] == 5'd31) begin
            m_vld[i][k] = 1'b0;
            if (m_dod[i] < 255) m_dod[i]++;
          end else begin
            m_y[i][k]++;
          end
        end
      end
    end
    if (m_nf[i] % SD[i] == SD[i] - 1) begin
      m_lfsr[i] = {m_lfsr[i][6:0], ^(m_lfsr[i] & 8'hB8)};
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found && !m_vld[i][k]) begin
          m_vld[i][k] = 1'b1;
          m_y[i][k]   = 5'd0;
          m_x[i][k]   = m_lfsr[i][2:0];
          found       = 1'b1;
        end
      end
    end
    m_nf[i]++;
  endtask

  task automatic model_step(input bit r, input bit e, input logic [3:0] h0, input logic [3:0] h1);
    bit tick;
    logic [3:0] hh [2];
    hh[0] = h0;
    hh[1] = h1;
    if (!r) begin
      for (int i = 0; i < 2; i++) begin
        m_vld[i] = '0; m_dod[i] = 0; m_lfsr[i] = 8'hA5; m_nf[i] = 0; m_age[i] = 0;
        for (int k = 0; k < 4; k++) begin
          m_x[i][k] = '0;
          m_y[i][k] = '0;
        end
      end
      en_cycles = 0;
      return;
    end
    tick = e && (en_cycles % (TICK + 1) == TICK);
    if (e) en_cycles++;
    for (int i = 0; i < 2; i++) begin
      case (m_age[i])
        0: if (tick) m_age[i] = 1;
        1: begin frame_update(i, hh[i]); m_age[i] = 2; end
        4: m_age[i] = 0;
        default: m_age[i]++;
      endcase
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("frame%0d", i), 32'(fr[i]), 32'(m_age[i] == 4));
      if (m_age[i] == 0 || m_age[i] == 4) begin
        check_eq($sformatf("vld%0d", i), 32'(bv[i]), 32'(m_vld[i]));
        check_eq($sformatf("dodged%0d", i), 32'(dd[i]), 32'(m_dod[i]));
        for (int k = 0; k < 4; k++) begin
          check_eq($sformatf("x%0d_%0d", i, k), 32'(bx[i][k*3 +: 3]), 32'(m_x[i][k]));
          check_eq($sformatf("y%0d_%0d", i, k), 32'(by[i][k*5 +: 5]), 32'(m_y[i][k]));
        end
      end
    end
  endtask

  // Hand-derived expectations at specific frames.
  task automatic directed();
    if ((ph == 1 || ph == 3) && m_age[0] == 4 && m_nf[0] == 1) begin
      check_eq("first_vld", 32'(bv[0]), 32'h1);
      check_eq("first_x", 32'(bx[0][2:0]), 32'd2);  // 8'hA5 shifted once = 8'h4A
      check_eq("first_y", 32'(by[0][4:0]), 32'd0);
    end
    if (ph == 1 && m_age[0] == 4) begin
      if (m_nf[0] == 4) check_eq("pool_full", 32'(bv[0]), 32'hF);
      if (m_nf[0] == 5) check_eq("spawn_skip", 32'(bv[0]), 32'hF);
      if (m_nf[0] == 6) begin
        check_eq("hit_refill_vld", 32'(bv[0]), 32'hF);
        check_eq("hit_refill_y", 32'(by[0][4:0]), 32'd0);
        check_eq("hit_no_dodge", 32'(dd[0]), 32'd0);
      end
    end
    if (ph == 1 && m_age[1] == 4) begin
      if (m_nf[1] == 71) begin
        check_eq("fall_vld", 32'(bv[1]), 32'h1);
        check_eq("fall_y31", 32'(by[1][4:0]), 32'd31);
      end
      if (m_nf[1] == 72) begin
        check_eq("exit_vld", 32'(bv[1]), 32'h0);
        check_eq("exit_dodged", 32'(dd[1]), 32'd1);
      end
    end
  endtask

  // Observe current outputs, then drive and model the next clock edge.
  task automatic cycle(input bit r, input bit e, input logic [3:0] h0, input logic [3:0] h1);
    if (chk_on) begin
      compare_all();
      directed();
    end
    rst    = r;
    en     = e;
    hit[0] = h0;
    hit[1] = h1;
    model_step(r, e, h0, h1);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] h0;
    rst    = 1'b0;
    en     = 1'b0;
    hit[0] = '0;
    hit[1] = '0;
    @(negedge clk);
    cycle(1'b0, 1'b0, 4'h0, 4'h0);
    chk_on = 1'b1;
    cycle(1'b0, 1'b0, 4'h0, 4'h0);
    cycle(1'b0, 1'b0, 4'h0, 4'h0);

    // Fill the pool, probe hits on empty and full slots, let dut1's lone bullet fall out.
    ph = 1;
    for (int c = 0; c < 600 && !(m_nf[1] >= 74 && m_age[1] == 0); c++) begin
      h0 = (m_nf[0] < 4) ? 4'b1000 : (m_nf[0] == 5) ? 4'b0001 : 4'b0000;
      cycle(1'b1, 1'b1, h0, 4'h0);
    end
    check_eq("phase_a_done", 32'(m_nf[1] >= 74), 32'd1);

    // Freeze: no frames, positions hold, tick count resumes afterwards.
    ph = 2;
    for (int c = 0; c < 100; c++) cycle(1'b1, 1'b0, 4'($urandom), 4'($urandom));

    for (int c = 0; c < 400; c++) begin
      cycle(1'b1, ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
    end

    // Reset while the FSM is in its move step.
    ph = 4;
    for (int c = 0; c < 20 && m_age[0] != 2; c++) cycle(1'b1, 1'b1, 4'h0, 4'h0);
    check_eq("reach_move", 32'(m_age[0]), 32'd2);
    cycle(1'b0, 1'b1, 4'h0, 4'h0);
    check_eq("rst_vld0", 32'(bv[0]), 32'h0);
    check_eq("rst_dod0", 32'(dd[0]), 32'h0);
    check_eq("rst_frame0", 32'(fr[0]), 32'h0);
    check_eq("rst_dod1", 32'(dd[1]), 32'h0);

    ph = 3;
    for (int c = 0; c < 20; c++) cycle(1'b1, 1'b1, 4'h0, 4'h0);
    check_eq("post_rst_frames", 32'(m_nf[0] >= 2), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
